// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU): 33 cycles from start to done, or 2 with DIV_ZERO_FAST_EN.
// Holds the pipeline via combinational stall_req while busy; annul aborts an operation in flight.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              signed_op,
    input  logic              annul,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_r, quo_r, dvs_mag, dvd_raw;
    logic              neg_q, neg_r, dvs_zero;
    logic              accept, finish;
    logic [DATA_W-1:0] dvd_abs, dvs_abs;
    logic [DATA_W:0]   trial;
    logic              ge;
    logic [DATA_W-1:0] rem_step, quo_step, q_res, r_res;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !annul) begin
                    accept    = 1'b1;
                    stall_req = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    state_nxt = (divisor == '0) ? ZERO : RUN;
`else
                    state_nxt = RUN;
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            ZERO: begin
                stall_req = 1'b1;
                state_nxt = annul ? IDLE : DONE;
            end
`endif
            RUN: begin
                stall_req = 1'b1;
                if (annul)                           state_nxt = IDLE;
                else if (cnt == CNT_W'(DATA_W - 1))  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!rst_n) stall_req = 1'b0;
    end

    assign finish = (state_nxt == DONE);

    assign dvd_abs = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
    assign dvs_abs = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;

    // Partial remainder is always below the divisor, so a set top bit of the
    // shifted value guarantees the subtract fits and the result fits DATA_W bits.
    always_comb begin
        trial = {rem_r, quo_r[DATA_W-1]};
        ge    = trial[DATA_W] || (trial[DATA_W-1:0] >= dvs_mag);
        if (ge) begin
            rem_step = trial[DATA_W-1:0] - dvs_mag;
            quo_step = {quo_r[DATA_W-2:0], 1'b1};
        end else begin
            rem_step = trial[DATA_W-1:0];
            quo_step = {quo_r[DATA_W-2:0], 1'b0};
        end
        q_res = dvs_zero ? '1      : (neg_q ? -quo_step : quo_step);
        r_res = dvs_zero ? dvd_raw : (neg_r ? -rem_step : rem_step);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_mag     <= '0;
            dvd_raw     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dvs_zero    <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                cnt      <= '0;
                rem_r    <= '0;
                quo_r    <= dvd_abs;
                dvs_mag  <= dvs_abs;
                dvd_raw  <= dividend;
                neg_q    <= signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                neg_r    <= signed_op && dividend[DATA_W-1];
                dvs_zero <= (divisor == '0);
            end else if (state == RUN) begin
                cnt   <= cnt + 1'b1;
                rem_r <= rem_step;
                quo_r <= quo_step;
            end
            if (finish) begin
                quotient    <= q_res;
                remainder   <= r_res;
                div_by_zero <= dvs_zero;
            end
        end
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand and result width (equals `DataBus` width).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request from EX to begin a DIV/DIVU.
REQ-005 SHALL have port signed_op, input, 1, 1=DIV, 0=DIVU; sampled with start.
REQ-006 SHALL have port annul, input, 1, flush from exception/branch; cancels the operation in flight.
REQ-007 SHALL have ports dividend and divisor, input, DATA_W each, operands sampled with start.
REQ-008 SHALL have port stall_req, output, 1, combinational pipeline-stall request.
REQ-009 SHALL have port done, output, 1, registered one-cycle result-valid pulse.
REQ-010 SHALL have ports quotient and remainder, output, DATA_W each, registered results: quotient goes to LO, remainder to HI.
REQ-011 SHALL have port div_by_zero, output, 1, registered; valid with done.

Function
REQ-012 SHALL implement states IDLE, ZERO, RUN and DONE.
REQ-013 IDLE: a start with annul=0 at cycle T SHALL latch operands and signed_op; next state is ZERO if divisor==0 and DIV_ZERO_FAST_EN is defined, else RUN.
REQ-014 RUN SHALL perform one restoring shift-subtract step per cycle on absolute magnitudes, 5-bit counter 0..31, then go to DONE: done=1 at T+33.
REQ-015 ZERO SHALL last one cycle, then go to DONE: done=1 at T+2.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE; start is accepted again from T+34 (T+3 for the ZERO path).
REQ-017 Signed: quotient SHALL be negated iff the operand signs differ; remainder SHALL take the sign of the dividend.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0.
REQ-019 Divisor zero, either path: quotient SHALL be 0xFFFFFFFF, remainder SHALL be the raw dividend, div_by_zero=1; otherwise div_by_zero=0.
REQ-020 stall_req SHALL be 1 when (IDLE and start and !annul), in RUN, and in ZERO; 0 in DONE and in IDLE otherwise.
REQ-021 quotient, remainder and div_by_zero SHALL update only on entering DONE and hold until the next DONE.
REQ-022 start asserted outside IDLE SHALL be ignored.
REQ-023 annul in RUN or ZERO SHALL force IDLE next cycle, with no done and outputs unchanged; annul in DONE SHALL not suppress that cycle's done.
REQ-024 annul and start together in IDLE SHALL not start an operation.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, counter=0, done=0, div_by_zero=0, quotient=0 and remainder=0; this aborts any operation in flight.
REQ-026 stall_req SHALL be 0 whenever rst_n=0.

Configuration
REQ-027 Macro DIV_ZERO_FAST_EN defined SHALL enable the ZERO state: a zero divisor completes with done at T+2.
REQ-028 Macro DIV_ZERO_FAST_EN undefined SHALL remove the ZERO state: a zero divisor runs through RUN with done at T+33, and the results are forced per REQ-019.

Verification
REQ-029 DIVU 100/7, start at T -> stall_req 1 over T..T+32, done at T+33 only, quotient=14, remainder=2.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, div_by_zero=0.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-032 DIVU 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; done at T+2 with the macro, T+33 without.
REQ-033 DIVU 100/7 with annul at T+10 -> IDLE at T+11, no done, outputs keep their prior values; a new start at T+11 gives done at T+44.
REQ-034 rst_n=0 at T+20 of an operation -> IDLE next cycle, all outputs 0, no done; start at T+22 is accepted normally.
